// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped one-word-line data cache between the core
// data port and slow memory, write-through or write-back by parameter.
//
// Ports
//   clk, reset          clock, async active-low reset
//   core_addr/wdata     core byte address (bits 1:0 unused), store data
//   core_rd/core_wr     load/store request, held while core_stall=1
//   core_rdata/hit      load data, combinational lookup hit
//   core_stall          request present and not completing this cycle
//   mem_addr/wdata      word-aligned memory address, write data
//   mem_rd/read_ready   read request / read data valid
//   mem_rdata           read data from memory
//   mem_read_done       read data captured
//   mem_wr/write_ready  write request / address+data valid
//   mem_write_done      memory accepted write
module dcache_ctrl #(
  parameter int NUM_LINES  = 16,
  parameter int WRITE_BACK = 0,
  parameter int INDEX_W    = $clog2(NUM_LINES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic        core_rd,
  input  logic        core_wr,
  output logic [31:0] core_rdata,
  output logic        core_hit,
  output logic        core_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  input  logic        mem_read_ready,
  input  logic [31:0] mem_rdata,
  output logic        mem_read_done,
  output logic        mem_wr,
  output logic        mem_write_ready,
  input  logic        mem_write_done
);

  localparam int TAG_W = 30 - INDEX_W;
  localparam bit WB = (WRITE_BACK != 0);

  typedef enum logic [2:0] {
    IDLE, EVICT, EVICT_DROP, FILL,
    FILL_DROP, WTHRU, WTHRU_DROP
  } state_t;

  state_t               state;
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tags [NUM_LINES];
  logic [31:0]          data [NUM_LINES];
  logic                 wt_done;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tg;
  logic               req;
  logic               is_wr;
  logic               hit;
  logic               vic_dirty;
  logic [31:0]        waddr;
  logic               line_we;
  logic [31:0]        line_data;
  logic               unused;

  assign idx       = core_addr[INDEX_W+1:2];
  assign tg        = core_addr[31:INDEX_W+2];
  assign req       = core_rd | core_wr;
  assign is_wr     = core_wr;
  assign hit       = valid[idx] && (tags[idx] == tg);
  assign vic_dirty = WB && valid[idx] && dirty[idx];
  assign waddr     = {core_addr[31:2], 2'b00};
  assign unused    = ^core_addr[1:0];

  assign core_hit   = reset && req && hit;
  assign core_rdata = (reset && core_rd && hit)
                    ? data[idx] : 32'h0;

  // wt_done marks the single completion cycle
  // of a write-through store back in IDLE.
  always_comb begin
    core_stall = 1'b0;
    if (reset && req) begin
      if (state != IDLE)
        core_stall = 1'b1;
      else if (is_wr)
        core_stall = WB ? (!hit && vic_dirty)
                        : !wt_done;
      else
        core_stall = !hit;
    end
  end

  always_comb begin
    line_we   = 1'b0;
    line_data = core_wdata;
    if (reset && state == IDLE && req && is_wr)
      line_we = WB ? (hit || !vic_dirty)
                   : (hit && !wt_done);
    if (reset && state == FILL && mem_read_ready) begin
      line_we   = 1'b1;
      line_data = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      data[idx] <= line_data;
      tags[idx] <= tg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      valid           <= '0;
      dirty           <= '0;
      wt_done         <= 1'b0;
      mem_addr        <= 32'h0;
      mem_wdata       <= 32'h0;
      mem_rd          <= 1'b0;
      mem_read_done   <= 1'b0;
      mem_wr          <= 1'b0;
      mem_write_ready <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          wt_done <= 1'b0;
          if (req && is_wr) begin
            if (WB) begin
              if (hit || !vic_dirty) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b1;
              end else begin
                state           <= EVICT;
                mem_wr          <= 1'b1;
                mem_write_ready <= 1'b1;
                mem_addr  <= {tags[idx], idx, 2'b00};
                mem_wdata <= data[idx];
              end
            end else if (!wt_done) begin
              state           <= WTHRU;
              mem_wr          <= 1'b1;
              mem_write_ready <= 1'b1;
              mem_addr        <= waddr;
              mem_wdata       <= core_wdata;
            end
          end else if (req && !hit) begin
            if (vic_dirty) begin
              state           <= EVICT;
              mem_wr          <= 1'b1;
              mem_write_ready <= 1'b1;
              mem_addr  <= {tags[idx], idx, 2'b00};
              mem_wdata <= data[idx];
            end else begin
              state    <= FILL;
              mem_rd   <= 1'b1;
              mem_addr <= waddr;
            end
          end
        end
        EVICT: begin
          if (mem_write_done) begin
            mem_wr          <= 1'b0;
            mem_write_ready <= 1'b0;
            dirty[idx]      <= 1'b0;
            state           <= EVICT_DROP;
          end
        end
        EVICT_DROP: begin
          if (!mem_write_done) begin
            if (is_wr) begin
              state <= IDLE;
            end else begin
              state    <= FILL;
              mem_rd   <= 1'b1;
              mem_addr <= waddr;
            end
          end
        end
        FILL: begin
          if (mem_read_ready) begin
            valid[idx]    <= 1'b1;
            dirty[idx]    <= 1'b0;
            mem_read_done <= 1'b1;
            state         <= FILL_DROP;
          end
        end
        FILL_DROP: begin
          if (!mem_read_ready) begin
            mem_rd        <= 1'b0;
            mem_read_done <= 1'b0;
            state         <= IDLE;
          end
        end
        WTHRU: begin
          if (mem_write_done) begin
            mem_wr          <= 1'b0;
            mem_write_ready <= 1'b0;
            state           <= WTHRU_DROP;
          end
        end
        WTHRU_DROP: begin
          if (!mem_write_done) begin
            wt_done <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
